satagtx_clk_seq: RTL and testbench

//  Parametrised clock/reset sequencer for N GTX tiles sharing one MGT_USRCLK_SOURCE DCM.

---
 rtl/satagtx_clk_seq_pkg.sv | 14 +
 rtl/satagtx_clk_seq_sync2.sv | 13 +
 rtl/satagtx_clk_seq.sv | 94 +++++++++
 tb/tb_satagtx_clk_seq.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/satagtx_clk_seq_pkg.sv
// satagtx_clk_seq_pkg: state encoding, parameter defaults and helpers for the GTX clock/reset sequencer
package satagtx_clk_seq_pkg;
  typedef enum logic [2:0] {WAIT_PLL, DCM_RST, WAIT_LOCK, SETTLE, REL, RUN, FAULT} state_t;
  localparam int DEF_NUM_CH = 2;
  localparam int DEF_RST_PULSE = 16;
  localparam int DEF_LOCK_TIMEOUT = 65535;
  localparam int DEF_SETTLE = 256;
  localparam int DEF_STAGGER = 8;
  localparam int DEF_MAX_RETRY = 7;
  localparam int DEF_CNT_W = 16;
  function automatic logic [7:0] lowest_set(input logic [7:0] v);
    return v & (~v + 8'd1);
  endfunction
endpackage

// File: rtl/satagtx_clk_seq_sync2.sv
// satagtx_clk_seq_sync2: two-flop synchroniser for a single asynchronous level
//   clk, rst (async, active-high, clears to 0); d in; q out (d delayed two clk edges)
module satagtx_clk_seq_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/satagtx_clk_seq.sv
// satagtx_clk_seq: bring-up sequencer for GTX tiles sharing one usrclk DCM
//   in : clk, rst (async, active-high), plllkdet[C_NUM_CH], dcm_locked, ch_mask[C_NUM_CH], force_rst
//   out: dcm_reset, ch_rst[C_NUM_CH], ch_ready[C_NUM_CH], all_ready, fault, retry_cnt[2:0] (all registered)
module satagtx_clk_seq
  import satagtx_clk_seq_pkg::*;
#(
  parameter int C_NUM_CH = DEF_NUM_CH,
  parameter int C_RST_PULSE = DEF_RST_PULSE,
  parameter int C_LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int C_SETTLE = DEF_SETTLE,
  parameter int C_STAGGER = DEF_STAGGER,
  parameter int C_MAX_RETRY = DEF_MAX_RETRY,
  parameter int C_CNT_W = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [C_NUM_CH-1:0] plllkdet,
  input  logic                dcm_locked,
  input  logic [C_NUM_CH-1:0] ch_mask,
  input  logic                force_rst,
  output logic                dcm_reset,
  output logic [C_NUM_CH-1:0] ch_rst,
  output logic [C_NUM_CH-1:0] ch_ready,
  output logic                all_ready,
  output logic                fault,
  output logic [2:0]          retry_cnt
);
  logic [C_NUM_CH-1:0] pll_s, mask_q, rel, rel_n, pend, first, ch_rst_n, ch_ready_n;
  logic lock_s, pll_ok, fail, unmask, rel_step, dcm_reset_n;
  logic [2:0] rc_inc, rc_n;
  logic [C_CNT_W-1:0] cnt;
  state_t state, ns, retry_ns;
  for (genvar i = 0; i < C_NUM_CH; i++) begin : g_sync
    satagtx_clk_seq_sync2 u_pll (.clk(clk), .rst(rst), .d(plllkdet[i]), .q(pll_s[i]));
  end
  satagtx_clk_seq_sync2 u_lock (.clk(clk), .rst(rst), .d(dcm_locked), .q(lock_s));
  assign pll_ok = &(pll_s | ~ch_mask) & |ch_mask;
  // rel marks channels already let out of reset; pend is what REL still has to release
  assign pend = ch_mask & ~rel;
  assign first = C_NUM_CH'(lowest_set(8'(pend)));
  assign rc_inc = retry_cnt + 3'd1;
  assign retry_ns = (rc_inc == 3'(C_MAX_RETRY)) ? FAULT : DCM_RST;
  // a lost lock in SETTLE or an expired wait in WAIT_LOCK both consume one attempt
  assign fail = !lock_s && (state == SETTLE || (state == WAIT_LOCK && cnt == C_CNT_W'(C_LOCK_TIMEOUT - 1)));
  assign unmask = (state == REL || state == RUN) && |(ch_mask & ~mask_q);
  assign rel_step = (state == SETTLE && !fail && cnt == C_CNT_W'(C_SETTLE - 1)) ||
                    (state == REL && |pend && cnt == C_CNT_W'(C_STAGGER - 1));
  always_comb begin
    ns = state;
    case (state)
      WAIT_PLL:  ns = pll_ok ? DCM_RST : WAIT_PLL;
      DCM_RST:   ns = !pll_ok ? WAIT_PLL : cnt == C_CNT_W'(C_RST_PULSE - 1) ? WAIT_LOCK : DCM_RST;
      WAIT_LOCK: ns = lock_s ? SETTLE : fail ? retry_ns : WAIT_LOCK;
      SETTLE:    ns = fail ? retry_ns : rel_step ? REL : SETTLE;
      REL:       ns = unmask ? WAIT_PLL : |pend ? REL : RUN;
      RUN:       ns = (unmask || !pll_ok || !lock_s) ? WAIT_PLL : RUN;
      FAULT:     ns = FAULT;
      default:   ns = WAIT_PLL;
    endcase
    if (force_rst) ns = WAIT_PLL;
  end
  always_comb begin
    rel_n = (ns == WAIT_PLL) ? '0 : rel | (rel_step ? first : '0);
    rc_n = (ns == WAIT_PLL) ? 3'd0 : fail ? rc_inc : retry_cnt;
    dcm_reset_n = ns inside {WAIT_PLL, DCM_RST, FAULT};
    ch_rst_n = ~(rel_n & ch_mask);
    // ready follows the reset release by one cycle
    ch_ready_n = rel_n & ch_mask & ~ch_rst;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= WAIT_PLL;
      cnt <= '0;
      rel <= '0;
      mask_q <= '0;
      retry_cnt <= 3'd0;
      dcm_reset <= 1'b1;
      ch_rst <= '1;
      ch_ready <= '0;
      all_ready <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= ns;
      cnt <= (ns != state || (state == REL && rel_step)) ? '0 : &cnt ? cnt : cnt + C_CNT_W'(1);
      rel <= rel_n;
      mask_q <= ch_mask;
      retry_cnt <= rc_n;
      dcm_reset <= dcm_reset_n;
      ch_rst <= ch_rst_n;
      ch_ready <= ch_ready_n;
      all_ready <= ns == RUN;
      fault <= ns == FAULT;
    end
endmodule

// File: tb/tb_satagtx_clk_seq.sv
// tb_satagtx_clk_seq: randomized bring-up scenarios checked against an event-time model
module tb_satagtx_clk_seq;
  logic clk = 1'b0;
  logic rst, dcm_locked, force_rst, dcm_reset, all_ready, fault;
  logic [1:0] plllkdet, ch_mask, ch_rst, ch_ready;
  logic [2:0] retry_cnt;
  logic [9:0] obs;
  int t = 0;
  int n_chk = 0;
  int n_fail = 0;
  localparam logic [9:0] RST_OBS = {1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 3'd0};

  satagtx_clk_seq #(.C_LOCK_TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .plllkdet(plllkdet), .dcm_locked(dcm_locked), .ch_mask(ch_mask),
    .force_rst(force_rst), .dcm_reset(dcm_reset), .ch_rst(ch_rst), .ch_ready(ch_ready),
    .all_ready(all_ready), .fault(fault), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;
  assign obs = {dcm_reset, ch_rst, ch_ready, all_ready, fault, retry_cnt};

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  // Bring-up from WAIT_PLL: inputs set now reach the FSM 3 edges later, the DCM pulse is
  // 16 cycles, SETTLE 256 cycles, then releases every 8 cycles; u>0 drops lock u cycles
  // after the first lock request, forcing one retry. abort>0 stops abort cycles into REL.
  task automatic bringup(input logic [1:0] m, input logic [1:0] p, input int d, input int u, input int abort);
    int f1, f2, dd, r0, rl, t_end, n;
    int rt [2];
    logic [1:0] e_rst, e_rdy;
    logic e_dr;
    logic [2:0] e_rc;
    ch_mask = m;
    plllkdet = p;
    dcm_locked = 1'b0;
    f1 = t + 19;
    dd = f1 + d + u;
    f2 = dd + 19;
    r0 = (u == 0) ? f1 + d + 259 : f2 + d + 259;
    n = 0;
    rl = r0;
    for (int i = 0; i < 2; i++) begin
      rt[i] = m[i] ? r0 + 8 * n : 32'h3fff_ffff;
      if (m[i]) begin
        rl = rt[i];
        n++;
      end
    end
    t_end = (abort > 0) ? r0 + abort : rl + 4;
    while (t < t_end) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        e_rst[i] = t < rt[i];
        e_rdy[i] = t > rt[i];
      end
      e_dr = t < f1 || (u != 0 && t >= dd + 3 && t < f2);
      e_rc = (u != 0 && t >= dd + 3) ? 3'd1 : 3'd0;
      chk("bringup", obs, {e_dr, e_rst, e_rdy, t > rl, 1'b0, e_rc});
      if (t == f1 + d || (u != 0 && t == f2 + d)) dcm_locked = 1'b1;
      if (u != 0 && t == dd) dcm_locked = 1'b0;
    end
  endtask

  task automatic run_drop(input logic [1:0] m, input int ch, input logic [2:0] rc);
    plllkdet[ch] = 1'b0;
    tick();
    tick();
    chk("run_hold", obs, {1'b0, ~m, m, 1'b1, 1'b0, rc});
    tick();
    chk("run_drop", obs, RST_OBS);
  endtask

  // Lock never arrives: each attempt is 100 cycles waiting plus 16 cycles of DCM reset.
  task automatic timeout_run();
    int f1, falls, rc;
    logic prev, fl, dr;
    ch_mask = 2'b11;
    plllkdet = 2'b11;
    dcm_locked = 1'b0;
    f1 = t + 19;
    falls = 0;
    prev = dcm_reset;
    while (t < f1 + 6 * 116 + 110) begin
      tick();
      rc = (t < f1) ? 0 : (t - f1 + 16) / 116;
      if (rc > 7) rc = 7;
      fl = rc == 7;
      dr = t < f1 || fl || (t - f1) % 116 >= 100;
      chk("timeout", obs, {dr, 2'b11, 2'b00, 1'b0, fl, 3'(rc)});
      if (prev && !dcm_reset) falls++;
      prev = dcm_reset;
    end
    chk("retry_pulses", falls, 7);
  endtask

  initial begin
    logic [1:0] m;
    int d, u, ch;
    rst = 1'b1;
    ch_mask = 2'b00;
    plllkdet = 2'b00;
    dcm_locked = 1'b0;
    force_rst = 1'b0;
    tick();
    tick();
    chk("reset", obs, RST_OBS);
    rst = 1'b0;
    bringup(2'b11, 2'b11, 40, 0, 0);
    run_drop(2'b11, 1, 3'd0);
    bringup(2'b10, 2'b10, 30, 100, 0);
    run_drop(2'b10, 1, 3'd1);
    repeat (4) begin
      m = 2'($urandom_range(3, 1));
      d = $urandom_range(90, 1);
      u = $urandom_range(1) ? $urandom_range(200, 10) : 0;
      bringup(m, m | 2'($urandom), d, u, 0);
      ch = (m == 2'b11) ? $urandom_range(1) : (m[1] ? 1 : 0);
      run_drop(m, ch, (u != 0) ? 3'd1 : 3'd0);
    end
    bringup(2'b11, 2'b11, $urandom_range(90, 1), 0, 0);
    ch_mask = 2'b01;
    tick();
    chk("mask_off", obs, {1'b0, 2'b10, 2'b01, 1'b1, 1'b0, 3'd0});
    ch_mask = 2'b11;
    tick();
    chk("unmask", obs, RST_OBS);
    ch_mask = 2'b00;
    repeat (5) tick();
    repeat (40) begin
      tick();
      chk("mask_none", obs, RST_OBS);
    end
    plllkdet = 2'b00;
    repeat (3) tick();
    bringup(2'b11, 2'b11, $urandom_range(90, 1), 0, 3);
    rst = 1'b1;
    #1;
    chk("rst_async", obs, RST_OBS);
    tick();
    rst = 1'b0;
    timeout_run();
    force_rst = 1'b1;
    tick();
    force_rst = 1'b0;
    chk("force_rst", obs, RST_OBS);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
